sr_flip_flop_tt: RTL and testbench



---
 rtl/sr_flip_flop_tt.sv | 40 ++++
 tb/tb_sr_flip_flop_tt.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sr_flip_flop_tt.sv
// Bank of independent clocked SR flip-flops, truth-table style.
// s=r=1 is treated as hold, so q and qbar stay valid and complementary.
module sr_flip_flop_tt #(
    parameter int unsigned WIDTH = 1
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clock,
    input  logic             reset
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({s[i], r[i]})
                2'b01:   state_d[i] = 1'b0;
                2'b10:   state_d[i] = 1'b1;
                default: state_d[i] = state_q[i];
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    // qbar comes from the same register, so it can never disagree with q.
    assign q    = state_q;
    assign qbar = ~state_q;

endmodule

// File: tb/tb_sr_flip_flop_tt.sv
// Directed bench for sr_flip_flop_tt: a 1-bit and a 4-bit instance on a shared clock/reset.
module tb_sr_flip_flop_tt;

    logic       clock;
    logic       reset;
    logic       s1, r1;
    logic       q1, qb1;
    logic [3:0] s4, r4;
    logic [3:0] q4, qb4;

    int n_checks;
    int n_errors;

    sr_flip_flop_tt #(.WIDTH(1)) u_dut1 (
        .q     (q1),
        .qbar  (qb1),
        .s     (s1),
        .r     (r1),
        .clock (clock),
        .reset (reset)
    );

    sr_flip_flop_tt #(.WIDTH(4)) u_dut4 (
        .q     (q4),
        .qbar  (qb4),
        .s     (s4),
        .r     (r4),
        .clock (clock),
        .reset (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled and inputs driven here.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        s1 = 1'b1;
        r1 = 1'b0;
        s4 = 4'b0000;
        r4 = 4'b0000;

        // Reset overrides s=1.
        step();
        check("rst_q1", {3'b0, q1}, 4'h0);
        check("rst_qb1", {3'b0, qb1}, 4'h1);
        check("rst_q4", q4, 4'h0);
        check("rst_qb4", qb4, 4'hF);
        reset = 1'b0;

        step();
        check("set_after_rst_q", {3'b0, q1}, 4'h1);
        check("set_after_rst_qb", {3'b0, qb1}, 4'h0);

        // Clear then hold.
        s1 = 1'b0;
        r1 = 1'b1;
        step();
        check("clr_q", {3'b0, q1}, 4'h0);
        check("clr_qb", {3'b0, qb1}, 4'h1);
        r1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold0_q", {3'b0, q1}, 4'h0);
        end

        // Set then hold.
        s1 = 1'b1;
        step();
        check("set_q", {3'b0, q1}, 4'h1);
        check("set_qb", {3'b0, qb1}, 4'h0);
        s1 = 1'b0;
        step();
        check("hold1_q", {3'b0, q1}, 4'h1);

        // Forbidden from q=1 and from q=0.
        s1 = 1'b1;
        r1 = 1'b1;
        step();
        check("forb1_q", {3'b0, q1}, 4'h1);
        check("forb1_qb", {3'b0, qb1}, 4'h0);
        s1 = 1'b0;
        step();
        check("clr2_q", {3'b0, q1}, 4'h0);
        s1 = 1'b1;
        step();
        check("forb0_q", {3'b0, q1}, 4'h0);
        check("forb0_qb", {3'b0, qb1}, 4'h1);

        // A set pulse entirely between edges is ignored.
        s1 = 1'b0;
        r1 = 1'b0;
        #5;
        s1 = 1'b1;
        #2;
        check("midpulse_stable_q", {3'b0, q1}, 4'h0);
        s1 = 1'b0;
        step();
        check("midpulse_q", {3'b0, q1}, 4'h0);

        // Reset mid-sequence while s=1, set lands after reset drops.
        s1 = 1'b1;
        step();
        check("set3_q", {3'b0, q1}, 4'h1);
        reset = 1'b1;
        #3;
        check("rst_async_none_q", {3'b0, q1}, 4'h1);
        step();
        check("rst_mid_q", {3'b0, q1}, 4'h0);
        check("rst_mid_qb", {3'b0, qb1}, 4'h1);
        reset = 1'b0;
        step();
        check("set_post_rst_q", {3'b0, q1}, 4'h1);
        s1 = 1'b0;

        // 4-bit bank: independent bits.
        s4 = 4'b1010;
        r4 = 4'b0101;
        step();
        check("w4_set_q", q4, 4'b1010);
        check("w4_set_qb", qb4, 4'b0101);
        s4 = 4'b0011;
        r4 = 4'b0011;
        step();
        check("w4_forb_q", q4, 4'b1010);
        check("w4_forb_qb", qb4, 4'b0101);
        s4 = 4'b0100;
        r4 = 4'b1000;
        step();
        check("w4_mix_q", q4, 4'b0110);
        check("w4_mix_qb", qb4, 4'b1001);
        s4 = 4'b0000;
        r4 = 4'b0000;
        step();
        check("w4_hold_q", q4, 4'b0110);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
